uart_msg_sequencer: RTL and testbench
=====================================

Name: uart_msg_sequencer

Overview:
- Message scheduler that drives the byte-level UART transmitter.
- Fetches a fixed message from an internal ROM and presents it one byte at a time over a valid/ready handshake.
- After each complete message it inserts a fixed idle gap, then repeats while enabled.
- Sits between the top-level io pins and the UART transmitter; it alone decides when and what the UART sends.

Parameters:
- CLOCK_RATE, 1000, clk frequency in Hz; sets the default gap.
- GAP_CYCLES, CLOCK_RATE, idle cycles between messages; legal range ≥1. Benches override it to 4.
- MSG_LEN, 8, number of message bytes; legal range 1..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; 1 = start or continue message repetition.
- tx_ready  input  1  UART transmitter can accept a byte this cycle.
- tx_data  output  8  byte offered to the UART.
- tx_valid  output  1  tx_data is valid.
- busy  output  1  high in SEND or GAP.
- msg_count  output  8  completed-message counter.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - reset is sampled on the clk edge and overrides everything.
  - Reset values: state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, msg_count=0, byte index=0, gap counter=0.
  - Reset mid-message aborts the message immediately. No partial-message bookkeeping; msg_count is cleared.
- ROM contents (MSG_LEN=8): "HELLO!\r\n" = 48 45 4C 4C 4F 21 0D 0A.
  - For other MSG_LEN the first MSG_LEN entries of a 16-entry ROM are used.
  - Entries 8..15 are 00.
- Handshake
  - A transfer occurs in any cycle with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
  - tx_ready is ignored when tx_valid=0.
- IDLE
  - tx_valid=0, busy=0.
  - If enable=1, go to SEND next cycle with byte index=0.
  - In the first SEND cycle, tx_valid=1 and tx_data=ROM[0]. Latency enable→tx_valid is 1 cycle.
- SEND
  - busy=1, tx_valid=1, tx_data=ROM[index].
  - On a transfer with index<MSG_LEN-1: index+1. The next byte is presented in the following cycle and tx_valid stays 1, so back-to-back transfers run at 1 byte/cycle.
  - On a transfer with index=MSG_LEN-1:
    - next cycle state=GAP, tx_valid=0, index=0;
    - msg_count increments in that same next cycle, wrapping 8'hFF→8'h00;
    - gap counter is loaded with GAP_CYCLES-1.
  - enable is ignored in SEND; the message always completes.
- GAP
  - busy=1, tx_valid=0, tx_data holds its last value (don't-care to the consumer).
  - Counter decrements each cycle.
  - In the cycle the counter is 0:
    - enable=1 → next state SEND with index=0;
    - enable=0 → next state IDLE.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
  - With enable held high, the first byte of the next message is valid GAP_CYCLES+1 cycles after the last transfer.
- Boundary conditions
  - enable is sampled only in IDLE and in the final GAP cycle.
  - A 1-cycle enable pulse in IDLE sends exactly one message.
  - MSG_LEN=1: each message is a single transfer followed by GAP.
  - GAP_CYCLES=1: GAP lasts one cycle.

Test Plan (GAP_CYCLES=4, MSG_LEN=8):
- Reset, then enable=0 for 10 cycles → tx_valid=0, busy=0, msg_count=0 throughout.
- reset high for 1 cycle, then enable=1 and tx_ready=1 held:
  - tx_valid rises 1 cycle after enable;
  - 8 consecutive transfers 48 45 4C 4C 4F 21 0D 0A;
  - then 4 cycles with tx_valid=0;
  - then 48 again;
  - msg_count=1 during the gap.
- tx_ready low for 3 cycles while ROM[2] is offered → tx_data=4C and tx_valid=1 hold stable all 3 cycles; exactly one 4C transfer follows; the byte sequence is unchanged.
- Drop enable after the 3rd transfer → the message completes all 8 bytes, then 4 gap cycles, then IDLE (busy=0); msg_count=1.
- Assert reset during the 5th byte of message 2 → next cycle tx_valid=0, busy=0, msg_count=0. Re-enable → message restarts from 48.
- Run 256 messages with tx_ready=1 → msg_count wraps to 00 on the 256th completion.

Source files
------------

// File: rtl/uart_msg_sequencer.sv
// ---------------------------------------------------------------------------
// uart_msg_sequencer
//
// Schedules a fixed message from an internal 16-entry ROM into the byte-level
// UART transmitter. It offers one byte per cycle over a valid/ready handshake.
// After each full message it waits a fixed idle gap. It then repeats for as
// long as enable stays high.
//
// Parameters:
//   CLOCK_RATE  clk frequency in Hz; sets the default gap length
//   GAP_CYCLES  idle cycles between messages (>= 1)
//   MSG_LEN     number of ROM bytes per message (1..16)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_enable     level; 1 = start or continue message repetition
//   i_tx_ready   UART can accept a byte this cycle
//   o_tx_data    byte offered to the UART
//   o_tx_valid   o_tx_data is valid
//   o_busy       high while sending or in the inter-message gap
//   o_msg_count  completed-message counter (wraps)
// ---------------------------------------------------------------------------
module uart_msg_sequencer #(
    parameter int CLOCK_RATE = 1000,
    parameter int GAP_CYCLES = CLOCK_RATE,
    parameter int MSG_LEN    = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_busy,
    output logic [7:0] o_msg_count
);

    // Counter only needs to hold GAP_CYCLES-1; keep at least one bit.
    localparam int         GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_index;
    logic [GAP_W-1:0] r_gap;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_msg_count;

    state_t           w_state_next;
    logic [3:0]       w_index_next;
    logic [GAP_W-1:0] w_gap_next;
    logic [7:0]       w_tx_data_next;
    logic [7:0]       w_msg_count_next;
    logic             w_transfer;

    // Message ROM: "HELLO!\r\n" followed by zero padding.
    function automatic logic [7:0] romByte(input logic [3:0] idx);
        logic [7:0] value;
        case (idx)
            4'd0:    value = 8'h48;
            4'd1:    value = 8'h45;
            4'd2:    value = 8'h4C;
            4'd3:    value = 8'h4C;
            4'd4:    value = 8'h4F;
            4'd5:    value = 8'h21;
            4'd6:    value = 8'h0D;
            4'd7:    value = 8'h0A;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    assign w_transfer = (r_state == SEND) && i_tx_ready;

    // The data register is loaded one cycle ahead. The byte shown in SEND
    // therefore always matches r_index. It stays stable while the UART stalls.
    always_comb begin
        w_state_next     = r_state;
        w_index_next     = r_index;
        w_gap_next       = r_gap;
        w_tx_data_next   = r_tx_data;
        w_msg_count_next = r_msg_count;

        case (r_state)
            IDLE: begin
                if (i_enable) begin
                    w_state_next   = SEND;
                    w_index_next   = 4'd0;
                    w_tx_data_next = romByte(4'd0);
                end
            end
            SEND: begin
                if (w_transfer) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next     = GAP;
                        w_index_next     = 4'd0;
                        w_gap_next       = GAP_LOAD;
                        w_msg_count_next = r_msg_count + 8'd1;
                    end else begin
                        w_index_next   = r_index + 4'd1;
                        w_tx_data_next = romByte(r_index + 4'd1);
                    end
                end
            end
            GAP: begin
                // enable is looked at only in the last gap cycle.
                if (r_gap == '0) begin
                    if (i_enable) begin
                        w_state_next   = SEND;
                        w_index_next   = 4'd0;
                        w_tx_data_next = romByte(4'd0);
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_gap_next = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_index_next = 4'd0;
            end
        endcase
    end

    // State register; reset aborts any message in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_index     <= 4'd0;
            r_gap       <= '0;
            r_tx_data   <= 8'h00;
            r_msg_count <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_index     <= w_index_next;
            r_gap       <= w_gap_next;
            r_tx_data   <= w_tx_data_next;
            r_msg_count <= w_msg_count_next;
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = (r_state == SEND);
    assign o_busy      = (r_state != IDLE);
    assign o_msg_count = r_msg_count;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_msg_sequencer
//
// Directed testbench for uart_msg_sequencer with GAP_CYCLES=4 and MSG_LEN=8.
// Inputs change 1 time unit after each rising edge. Outputs are checked at
// that same point, so each check sees the state settled by the previous edge.
// ---------------------------------------------------------------------------
module tb_uart_msg_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       txReady;
    logic [7:0] txData;
    logic       txValid;
    logic       busy;
    logic [7:0] msgCount;

    int errors = 0;
    int checks = 0;

    logic [7:0] msgBytes [8];

    uart_msg_sequencer #(
        .CLOCK_RATE (1000),
        .GAP_CYCLES (4),
        .MSG_LEN    (8)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_tx_ready  (txReady),
        .o_tx_data   (txData),
        .o_tx_valid  (txValid),
        .o_busy      (busy),
        .o_msg_count (msgCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic rdy);
        reset   = rst;
        enable  = en;
        txReady = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic expectByte(input string tag, input logic [7:0] b);
        checkOutput({tag, " data"},  txData, b);
        checkOutput({tag, " valid"}, {7'd0, txValid}, 8'h01);
        checkOutput({tag, " busy"},  {7'd0, busy}, 8'h01);
    endtask

    task automatic expectGap(input string tag, input logic [7:0] cnt);
        checkOutput({tag, " valid"}, {7'd0, txValid}, 8'h00);
        checkOutput({tag, " busy"},  {7'd0, busy}, 8'h01);
        checkOutput({tag, " count"}, msgCount, cnt);
    endtask

    task automatic expectIdle(input string tag, input logic [7:0] cnt);
        checkOutput({tag, " valid"}, {7'd0, txValid}, 8'h00);
        checkOutput({tag, " busy"},  {7'd0, busy}, 8'h00);
        checkOutput({tag, " count"}, msgCount, cnt);
    endtask

    initial begin
        msgBytes = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h0D, 8'h0A};

        // Reset with everything quiet.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expectIdle("reset", 8'h00);
        checkOutput("reset data", txData, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Disabled: nothing happens for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            expectIdle($sformatf("disabled c%0d", i), 8'h00);
        end

        // Continuous run: enable and ready held high.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            expectByte($sformatf("msg1 b%0d", i), msgBytes[i]);
        end
        for (int g = 0; g < 4; g++) begin
            tick();
            expectGap($sformatf("msg1 gap%0d", g), 8'h01);
        end

        // Message 2 starts right after the gap, then stalls on byte 2.
        tick();
        expectByte("msg2 b0", 8'h48);
        tick();
        expectByte("msg2 b1", 8'h45);
        tick();
        expectByte("msg2 b2 stall0", 8'h4C);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        expectByte("msg2 b2 stall1", 8'h4C);
        tick();
        expectByte("msg2 b2 stall2", 8'h4C);
        tick();
        expectByte("msg2 b2 release", 8'h4C);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 3; i < 8; i++) begin
            tick();
            expectByte($sformatf("msg2 b%0d", i), msgBytes[i]);
        end
        for (int g = 0; g < 4; g++) begin
            tick();
            expectGap($sformatf("msg2 gap%0d", g), 8'h02);
        end

        // Message 3: reset while the 5th byte is on offer.
        for (int i = 0; i < 5; i++) begin
            tick();
            expectByte($sformatf("msg3 b%0d", i), msgBytes[i]);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        expectIdle("mid reset", 8'h00);
        checkOutput("mid reset data", txData, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1);

        // Restart from byte 0; drop enable after the 3rd transfer.
        for (int i = 0; i < 3; i++) begin
            tick();
            expectByte($sformatf("restart b%0d", i), msgBytes[i]);
        end
        tick();
        expectByte("restart b3", msgBytes[3]);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 4; i < 8; i++) begin
            tick();
            expectByte($sformatf("restart b%0d", i), msgBytes[i]);
        end
        for (int g = 0; g < 4; g++) begin
            tick();
            expectGap($sformatf("restart gap%0d", g), 8'h01);
        end
        tick();
        expectIdle("after stop", 8'h01);
        tick();
        expectIdle("still idle", 8'h01);

        // Long run: counter must wrap to 00 on the 256th completion.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int m = 1; m <= 256; m++) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                checkOutput($sformatf("wrap m%0d b%0d", m, i), txData, msgBytes[i]);
            end
            tick();
            expectGap($sformatf("wrap m%0d gap", m), 8'(m));
            if (m == 256) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
            end
            tick();
            tick();
            tick();
        end
        tick();
        expectIdle("wrap end", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
